// File: rtl/aes_trojan_monitor.sv
// rtl/aes_trojan_monitor.sv - trigger/payload runtime monitor beside aes_128
module aes_trojan_monitor #(
  parameter int           Q         = 4,
  parameter int           LAT       = 21,
  parameter int           STUCK     = 2,
  parameter logic [127:0] TRIG_MASK = 128'h2000_0000_0010_2000_0800_0100_0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pt_valid,
  input  logic [127:0] pt,
  input  logic [127:0] ct,
  input  logic         clr,
  output logic         trig_seen,
  output logic         armed,
  output logic         alarm,
  output logic [15:0]  event_cnt,
  output logic [31:0]  alarm_time
);

  localparam int RW = $clog2(Q + 1);
  localparam int OW = $clog2(STUCK + 1);
  localparam logic [RW-1:0] RUN_MAX   = RW'(Q);
  localparam logic [RW-1:0] RUN_LAST  = RW'(Q - 1);
  localparam logic [OW-1:0] ONES_LAST = OW'(STUCK - 1);

  typedef enum logic [1:0] {IDLE, COUNT, ARMED, ALARM} state_t;

  state_t         state;
  logic [RW-1:0]  run;
  logic [RW-1:0]  run_next;
  logic [OW-1:0]  ones;
  logic [31:0]    cyc;
  logic [LAT-1:0] vshift;

  logic match;
  logic complete;
  logic ct_ok;
  logic ct_ones;

  assign match    = (pt & TRIG_MASK) == TRIG_MASK;
  assign ct_ok    = vshift[LAT-1];
  assign ct_ones  = &ct;
  assign complete = pt_valid && match && (run == RUN_LAST);

  // Next trigger-run value: valid gaps hold, a non-matching input breaks the run, saturate at Q
  always_comb begin
    run_next = run;
    if (pt_valid) begin
      if (!match) begin
        run_next = '0;
      end else if (run != RUN_MAX) begin
        run_next = run + RW'(1);
      end
    end
  end

  // Delay line so each ciphertext is judged against the valid of the plaintext that produced it
  always_ff @(posedge clk) begin
    if (rst) begin
      vshift <= '0;
    end else begin
      vshift[0] <= pt_valid;
      for (int i = 1; i < LAT; i++) begin
        vshift[i] <= vshift[i-1];
      end
    end
  end

  // Free-running timestamp source, only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc <= '0;
    end else begin
      cyc <= cyc + 32'd1;
    end
  end

  // Monitor FSM: trigger counting, arming, payload run and sticky alarm
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      run        <= '0;
      ones       <= '0;
      trig_seen  <= 1'b0;
      armed      <= 1'b0;
      alarm      <= 1'b0;
      event_cnt  <= '0;
      alarm_time <= '0;
    end else if (clr) begin
      // clr drops any concurrent completion or alarm; history (event_cnt, alarm_time) is kept
      state     <= IDLE;
      run       <= '0;
      ones      <= '0;
      trig_seen <= 1'b0;
      armed     <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      run       <= run_next;
      trig_seen <= complete;
      if (complete && (event_cnt != 16'hFFFF)) begin
        event_cnt <= event_cnt + 16'd1;
      end
      case (state)
        IDLE, COUNT: begin
          if (complete) begin
            state <= ARMED;
            armed <= 1'b1;
          end else begin
            state <= (run_next == '0) ? IDLE : COUNT;
          end
        end
        ARMED: begin
          if (ct_ok) begin
            if (!ct_ones) begin
              ones <= '0;
            end else if (ones == ONES_LAST) begin
              state      <= ALARM;
              alarm      <= 1'b1;
              alarm_time <= cyc;
            end else begin
              ones <= ones + OW'(1);
            end
          end
        end
        ALARM: begin
          state <= ALARM;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_trojan_monitor.sv
// tb/tb_aes_trojan_monitor.sv - scoreboard bench for aes_trojan_monitor
module tb_aes_trojan_monitor;

  localparam int           Q         = 4;
  localparam int           LAT       = 21;
  localparam int           STUCK     = 2;
  localparam logic [127:0] TRIG_MASK = 128'h2000_0000_0010_2000_0800_0100_0000_0000;
  localparam logic [127:0] NORMAL    = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
  localparam logic [127:0] ONES      = {128{1'b1}};
  localparam logic [127:0] ZERO      = '0;

  logic         clk = 1'b0;
  logic         rst;
  logic         pt_valid;
  logic [127:0] pt;
  logic [127:0] ct;
  logic         clr;
  logic         trig_seen;
  logic         armed;
  logic         alarm;
  logic [15:0]  event_cnt;
  logic [31:0]  alarm_time;

  aes_trojan_monitor #(
    .Q(Q), .LAT(LAT), .STUCK(STUCK), .TRIG_MASK(TRIG_MASK)
  ) dut (
    .clk(clk), .rst(rst), .pt_valid(pt_valid), .pt(pt), .ct(ct), .clr(clr),
    .trig_seen(trig_seen), .armed(armed), .alarm(alarm),
    .event_cnt(event_cnt), .alarm_time(alarm_time)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        trig_seen;
    logic        armed;
    logic        alarm;
    logic [15:0] event_cnt;
    logic [31:0] alarm_time;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // reference model state
  int          m_run, m_ones, m_evt;
  logic        m_trig, m_armed, m_alarm;
  logic [31:0] m_cyc, m_atime;
  bit          vhist[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_edge(input logic r, input logic pv, input logic [127:0] p,
                            input logic [127:0] c, input logic cl);
    bit   aligned;
    logic mt, comp;
    if (r) begin
      m_run = 0; m_ones = 0; m_evt = 0;
      m_trig = 0; m_armed = 0; m_alarm = 0;
      m_cyc = 0; m_atime = 0;
      vhist.delete();
      for (int i = 0; i < LAT; i++) vhist.push_back(1'b0);
    end else begin
      aligned = vhist.pop_front();
      vhist.push_back(pv);
      if (cl) begin
        m_run = 0; m_ones = 0; m_trig = 0; m_armed = 0; m_alarm = 0;
      end else begin
        mt   = (p & TRIG_MASK) == TRIG_MASK;
        comp = pv && mt && (m_run == Q - 1);
        if (m_armed && !m_alarm && aligned) begin
          if (c == ONES) begin
            if (m_ones == STUCK - 1) begin
              m_alarm = 1;
              m_atime = m_cyc;
            end else begin
              m_ones++;
            end
          end else begin
            m_ones = 0;
          end
        end
        if (pv) m_run = !mt ? 0 : ((m_run < Q) ? m_run + 1 : Q);
        m_trig = comp;
        if (comp) begin
          m_armed = 1;
          if (m_evt < 65535) m_evt++;
        end
      end
      m_cyc = m_cyc + 32'd1;
    end
    sb_q.push_back('{m_trig, m_armed, m_alarm, 16'(m_evt), m_atime});
  endtask

  task automatic step(input logic r, input logic pv, input logic [127:0] p,
                      input logic [127:0] c, input logic cl);
    exp_t e;
    rst = r; pt_valid = pv; pt = p; ct = c; clr = cl;
    model_edge(r, pv, p, c, cl);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("sb_trig_seen",  64'(trig_seen),  64'(e.trig_seen));
    check_eq("sb_armed",      64'(armed),      64'(e.armed));
    check_eq("sb_alarm",      64'(alarm),      64'(e.alarm));
    check_eq("sb_event_cnt",  64'(event_cnt),  64'(e.event_cnt));
    check_eq("sb_alarm_time", 64'(alarm_time), 64'(e.alarm_time));
  endtask

  int          pulses;
  int          last_idx;
  logic [31:0] t_alarm;
  logic [127:0] rp;

  initial begin
    rst = 1'b1; pt_valid = 1'b0; pt = '0; ct = '0; clr = 1'b0;
    @(negedge clk);

    // reset with random inputs
    for (int i = 0; i < 2; i++) step(1'b1, 1'($urandom_range(0, 1)), rand128(), rand128(), 1'b0);
    check_eq("rst_trig_seen",  64'(trig_seen),  64'd0);
    check_eq("rst_armed",      64'(armed),      64'd0);
    check_eq("rst_alarm",      64'(alarm),      64'd0);
    check_eq("rst_event_cnt",  64'(event_cnt),  64'd0);
    check_eq("rst_alarm_time", 64'(alarm_time), 64'd0);

    // normal traffic never triggers
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, NORMAL, ZERO, 1'b0);
      if (trig_seen) pulses++;
    end
    check_eq("normal_pulses", 64'(pulses),    64'd0);
    check_eq("normal_armed",  64'(armed),     64'd0);
    check_eq("normal_events", 64'(event_cnt), 64'd0);

    // four consecutive matches complete a trigger, a fifth adds nothing
    for (int i = 0; i < Q; i++) step(1'b0, 1'b1, TRIG_MASK, ZERO, 1'b0);
    check_eq("trig_pulse",  64'(trig_seen), 64'd1);
    check_eq("trig_armed",  64'(armed),     64'd1);
    check_eq("trig_events", 64'(event_cnt), 64'd1);
    step(1'b0, 1'b1, TRIG_MASK, ZERO, 1'b0);
    check_eq("fifth_pulse",  64'(trig_seen), 64'd0);
    check_eq("fifth_events", 64'(event_cnt), 64'd1);

    // 3 matches, 1 normal, 4 matches: one event on the 8th plaintext
    pulses = 0; last_idx = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, (i == 3) ? NORMAL : TRIG_MASK, ZERO, 1'b0);
      if (trig_seen) begin pulses++; last_idx = i; end
    end
    check_eq("broken_pulses", 64'(pulses),    64'd1);
    check_eq("broken_index",  64'(last_idx),  64'd7);
    check_eq("broken_events", 64'(event_cnt), 64'd2);

    // all-ones plaintext with valid gaps between matches
    step(1'b0, 1'b1, NORMAL, ZERO, 1'b0);
    pulses = 0;
    for (int i = 0; i < Q; i++) begin
      step(1'b0, 1'b1, ONES, ZERO, 1'b0);
      if (trig_seen) pulses++;
      step(1'b0, 1'b0, NORMAL, ZERO, 1'b0);
      if (trig_seen) pulses++;
    end
    check_eq("gap_pulses", 64'(pulses),    64'd1);
    check_eq("gap_events", 64'(event_cnt), 64'd3);

    // payload: settle aligned traffic, one all-ones then other -> no alarm
    for (int i = 0; i < LAT + 3; i++) step(1'b0, 1'b1, NORMAL, ZERO, 1'b0);
    step(1'b0, 1'b1, NORMAL, ONES, 1'b0);
    step(1'b0, 1'b1, NORMAL, 128'h5, 1'b0);
    check_eq("single_ones_alarm", 64'(alarm), 64'd0);
    step(1'b0, 1'b1, NORMAL, ONES, 1'b0);
    check_eq("one_of_two_alarm", 64'(alarm), 64'd0);
    t_alarm = m_cyc;
    step(1'b0, 1'b1, NORMAL, ONES, 1'b0);
    check_eq("payload_alarm", 64'(alarm),      64'd1);
    check_eq("payload_time",  64'(alarm_time), 64'(t_alarm));
    step(1'b0, 1'b1, NORMAL, ZERO, 1'b0);
    check_eq("alarm_sticky", 64'(alarm), 64'd1);

    // clr together with a 4th trigger match wins
    step(1'b0, 1'b1, NORMAL, ZERO, 1'b0);
    for (int i = 0; i < Q - 1; i++) step(1'b0, 1'b1, TRIG_MASK, ZERO, 1'b0);
    step(1'b0, 1'b1, TRIG_MASK, ZERO, 1'b1);
    check_eq("clr_alarm",      64'(alarm),      64'd0);
    check_eq("clr_armed",      64'(armed),      64'd0);
    check_eq("clr_trig_seen",  64'(trig_seen),  64'd0);
    check_eq("clr_event_cnt",  64'(event_cnt),  64'd3);
    check_eq("clr_alarm_time", 64'(alarm_time), 64'(t_alarm));
    step(1'b0, 1'b1, TRIG_MASK, ZERO, 1'b0);
    check_eq("post_clr_pulse", 64'(trig_seen), 64'd0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: rp = TRIG_MASK;
        1: rp = ONES;
        2: rp = TRIG_MASK | rand128();
        default: rp = rand128();
      endcase
      step(1'b0, ($urandom_range(0, 3) != 0), rp,
           ($urandom_range(0, 1) != 0) ? ONES : rand128(),
           ($urandom_range(0, 39) == 0));
    end

    // reset mid-run discards the partial trigger run
    step(1'b0, 1'b1, NORMAL, ZERO, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, TRIG_MASK, ZERO, 1'b0);
    step(1'b1, 1'b1, TRIG_MASK, ZERO, 1'b0);
    pulses = 0;
    for (int i = 0; i < Q - 2; i++) begin
      step(1'b0, 1'b1, TRIG_MASK, ZERO, 1'b0);
      if (trig_seen) pulses++;
    end
    check_eq("rst_mid_pulses", 64'(pulses),    64'd0);
    check_eq("rst_mid_events", 64'(event_cnt), 64'd0);
    check_eq("rst_mid_armed",  64'(armed),     64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
